// File: rtl/universal_shift_register.sv
// ============================================================================
// Module   : universal_shift_register
// Purpose  : Parametrised bidirectional shift register with parallel load and
//            read, synchronous clear and frame counting. It serves as the
//            serialiser/deserialiser primitive for single-bit links.
//            Optional rotate modes (ROL/ROR) are built only when the macro
//            USR_ROTATE_EN is defined. Otherwise those modes hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_register #(
  parameter  int          WIDTH     = 8,
  parameter  logic [63:0] RESET_VAL = 64'd0,
  localparam int          CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  // Operation encodings on the mode input
  localparam logic [2:0] C_MODE_HOLD  = 3'b000;
  localparam logic [2:0] C_MODE_SHL   = 3'b001;
  localparam logic [2:0] C_MODE_SHR   = 3'b010;
  localparam logic [2:0] C_MODE_LOAD  = 3'b011;
  localparam logic [2:0] C_MODE_ROL   = 3'b100;
  localparam logic [2:0] C_MODE_ROR   = 3'b101;
  localparam logic [2:0] C_MODE_CLEAR = 3'b110;

  // Reset/clear value truncated to the register width
  localparam logic [WIDTH-1:0] C_RESET_VAL = RESET_VAL[WIDTH-1:0];
  // Last count value of a frame; the counter wraps here explicitly so that
  // widths that are not a power of two never reach values >= WIDTH.
  localparam logic [CW-1:0]    C_CNT_LAST  = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             done_q, done_d;
  logic             shift_w;

  // Next-state selection: new register value, counter and frame pulse
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shift_w = 1'b0;
    if (en) begin
      case (mode)
        C_MODE_SHL: begin
          data_d  = {data_q[WIDTH-2:0], sin_lsb};
          shift_w = 1'b1;
        end
        C_MODE_SHR: begin
          data_d  = {sin_msb, data_q[WIDTH-1:1]};
          shift_w = 1'b1;
        end
        C_MODE_LOAD: begin
          data_d = par_in;
          cnt_d  = '0;
        end
`ifdef USR_ROTATE_EN
        C_MODE_ROL: begin
          data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          shift_w = 1'b1;
        end
        C_MODE_ROR: begin
          data_d  = {data_q[0], data_q[WIDTH-1:1]};
          shift_w = 1'b1;
        end
`endif
        C_MODE_CLEAR: begin
          data_d = C_RESET_VAL;
          cnt_d  = '0;
        end
        default: begin
          // HOLD, reserved 111, and rotate codes when rotate is not built
          data_d = data_q;
        end
      endcase
      // Every shift counts toward the frame, regardless of direction
      if (shift_w) begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over all modes
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= C_RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Outputs are direct register views
  assign par_out    = data_q;
  assign sout_msb   = data_q[WIDTH-1];
  assign sout_lsb   = data_q[0];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

  // Mode constants only referenced through the case default when rotate is
  // absent; tie them into a harmless expression to keep them meaningful.
  logic unused_w;
  assign unused_w = ^{C_MODE_HOLD, C_MODE_ROL, C_MODE_ROR};

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// Module   : tb_universal_shift_register
// Purpose  : Self-checking bench for universal_shift_register (WIDTH=8).
//            It applies a table of vectors, then a back-to-back frame
//            sequence whose expected values come from a small reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_register;

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] SHL   = 3'b001;
  localparam logic [2:0] SHR   = 3'b010;
  localparam logic [2:0] LOAD  = 3'b011;
  localparam logic [2:0] ROL   = 3'b100;
  localparam logic [2:0] ROR   = 3'b101;
  localparam logic [2:0] CLEAR = 3'b110;
  localparam logic [2:0] RSVD  = 3'b111;

  logic       clk = 1'b0;
  logic       rst, en, sin_lsb, sin_msb;
  logic [2:0] mode;
  logic [7:0] par_in, par_out;
  logic       sout_msb, sout_lsb, frame_done;
  logic [2:0] shift_cnt;

  int total = 0;
  int bad   = 0;

  universal_shift_register #(.WIDTH(8), .RESET_VAL(64'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .par_in(par_in),
    .par_out(par_out), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       sl;
    logic       sm;
    logic [7:0] pin;
    logic [7:0] ep;
    logic [2:0] ec;
    logic       ed;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic void add(input logic r, input logic e, input logic [2:0] m,
                              input logic sl, input logic sm, input logic [7:0] pin,
                              input logic [7:0] ep, input logic [2:0] ec,
                              input logic ed, input string tag);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sl = sl; v.sm = sm; v.pin = pin;
    v.ep = ep; v.ec = ec; v.ed = ed; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, record its expectation, then
  // compare what the DUT shows one step after the next rising edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; mode = v.mode;
    sin_lsb = v.sl; sin_msb = v.sm; par_in = v.pin;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".par_out"},    par_out,           e.ep);
    check({e.tag, ".shift_cnt"},  {5'd0, shift_cnt}, {5'd0, e.ec});
    check({e.tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, e.ed});
    check({e.tag, ".sout_msb"},   {7'd0, sout_msb},  {7'd0, e.ep[7]});
    check({e.tag, ".sout_lsb"},   {7'd0, sout_lsb},  {7'd0, e.ep[0]});
  endtask

  initial begin
    vec_t v;
    logic [7:0] m_q;
    logic [2:0] m_cnt;
    logic       m_done;
    int         pulses;

    rst = 1'b1; en = 1'b0; mode = HOLD; sin_lsb = 1'b0; sin_msb = 1'b0; par_in = 8'h00;

    // Reset wins over LOAD
    add(1, 1, LOAD, 0, 0, 8'hFF, 8'h00, 3'd0, 0, "rst0");
    add(1, 1, LOAD, 0, 0, 8'hFF, 8'h00, 3'd0, 0, "rst1");
    // Deserialise 1,0,1,1,0,0,1,0 -> B2
    add(0, 1, SHL, 1, 0, 8'h00, 8'h01, 3'd1, 0, "des1");
    add(0, 1, SHL, 0, 0, 8'h00, 8'h02, 3'd2, 0, "des2");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h05, 3'd3, 0, "des3");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h0B, 3'd4, 0, "des4");
    add(0, 1, SHL, 0, 0, 8'h00, 8'h16, 3'd5, 0, "des5");
    add(0, 1, SHL, 0, 0, 8'h00, 8'h2C, 3'd6, 0, "des6");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h59, 3'd7, 0, "des7");
    add(0, 1, SHL, 0, 0, 8'h00, 8'hB2, 3'd0, 1, "des8");
    add(0, 1, HOLD, 1, 1, 8'h00, 8'hB2, 3'd0, 0, "hold");
    // Serialise A5 via SHR with sin_msb=0
    add(0, 1, LOAD, 0, 0, 8'hA5, 8'hA5, 3'd0, 0, "ld_a5");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h52, 3'd1, 0, "ser1");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h29, 3'd2, 0, "ser2");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h14, 3'd3, 0, "ser3");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h0A, 3'd4, 0, "ser4");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h05, 3'd5, 0, "ser5");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h02, 3'd6, 0, "ser6");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h01, 3'd7, 0, "ser7");
    add(0, 1, SHR, 0, 0, 8'h00, 8'h00, 3'd0, 1, "ser8");
    // Abort: 5 shifts, LOAD 3C, then a full 8-shift frame
    add(0, 1, SHL, 1, 0, 8'h00, 8'h01, 3'd1, 0, "ab1");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h03, 3'd2, 0, "ab2");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h07, 3'd3, 0, "ab3");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h0F, 3'd4, 0, "ab4");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h1F, 3'd5, 0, "ab5");
    add(0, 1, LOAD, 1, 0, 8'h3C, 8'h3C, 3'd0, 0, "ab_ld");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h79, 3'd1, 0, "ab_s1");
    add(0, 1, SHL, 1, 0, 8'h00, 8'hF3, 3'd2, 0, "ab_s2");
    add(0, 1, SHL, 1, 0, 8'h00, 8'hE7, 3'd3, 0, "ab_s3");
    add(0, 1, SHL, 1, 0, 8'h00, 8'hCF, 3'd4, 0, "ab_s4");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h9F, 3'd5, 0, "ab_s5");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h3F, 3'd6, 0, "ab_s6");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h7F, 3'd7, 0, "ab_s7");
    add(0, 1, SHL, 1, 0, 8'h00, 8'hFF, 3'd0, 1, "ab_s8");
    // Enable low and reserved mode freeze everything
    add(0, 1, SHL, 0, 0, 8'h00, 8'hFE, 3'd1, 0, "en_s");
    add(0, 0, SHL, 1, 1, 8'h55, 8'hFE, 3'd1, 0, "en0a");
    add(0, 0, SHL, 1, 1, 8'h55, 8'hFE, 3'd1, 0, "en0b");
    add(0, 0, LOAD, 1, 1, 8'h55, 8'hFE, 3'd1, 0, "en0c");
    add(0, 1, RSVD, 1, 1, 8'h55, 8'hFE, 3'd1, 0, "rsv1");
    add(0, 1, RSVD, 1, 1, 8'h55, 8'hFE, 3'd1, 0, "rsv2");
    // Mixed directions all count
    add(0, 1, SHL, 0, 0, 8'h00, 8'hFC, 3'd2, 0, "mix1");
    add(0, 1, SHR, 0, 1, 8'h00, 8'hFE, 3'd3, 0, "mix2");
    add(0, 1, CLEAR, 1, 1, 8'h77, 8'h00, 3'd0, 0, "clr");
    // Reset mid-frame
    add(0, 1, SHL, 1, 0, 8'h00, 8'h01, 3'd1, 0, "rm1");
    add(0, 1, SHL, 1, 0, 8'h00, 8'h03, 3'd2, 0, "rm2");
    add(1, 1, SHL, 1, 0, 8'h00, 8'h00, 3'd0, 0, "rm_rst");
    // Rotate
    add(0, 1, LOAD, 0, 0, 8'h81, 8'h81, 3'd0, 0, "rot_ld");
`ifdef USR_ROTATE_EN
    add(0, 1, ROL, 0, 0, 8'h00, 8'h03, 3'd1, 0, "rol1");
    add(0, 1, ROR, 1, 1, 8'h00, 8'h81, 3'd2, 0, "ror1");
    add(0, 1, ROR, 1, 1, 8'h00, 8'hC0, 3'd3, 0, "ror2");
    add(0, 1, LOAD, 0, 0, 8'h81, 8'h81, 3'd0, 0, "rot_ld2");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h03, 3'd1, 0, "r8_1");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h06, 3'd2, 0, "r8_2");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h0C, 3'd3, 0, "r8_3");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h18, 3'd4, 0, "r8_4");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h30, 3'd5, 0, "r8_5");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h60, 3'd6, 0, "r8_6");
    add(0, 1, ROL, 0, 0, 8'h00, 8'hC0, 3'd7, 0, "r8_7");
    add(0, 1, ROL, 0, 0, 8'h00, 8'h81, 3'd0, 1, "r8_8");
`else
    add(0, 1, ROL, 1, 1, 8'h00, 8'h81, 3'd0, 0, "rol1");
    add(0, 1, ROR, 1, 1, 8'h00, 8'h81, 3'd0, 0, "ror1");
    add(0, 1, ROR, 1, 1, 8'h00, 8'h81, 3'd0, 0, "ror2");
    for (int i = 0; i < 8; i++)
      add(0, 1, ROL, 1, 1, 8'h00, 8'h81, 3'd0, 0, "r8");
`endif

    foreach (vecs[i]) apply(vecs[i]);

    // Back-to-back frames: 16 SHL shifts against a reference model,
    // expecting exactly two pulses.
    v.rst = 0; v.en = 1; v.mode = CLEAR; v.sl = 0; v.sm = 0; v.pin = 8'h00;
    v.ep = 8'h00; v.ec = 3'd0; v.ed = 0; v.tag = "b2b_clr";
    apply(v);
    m_q = 8'h00; m_cnt = 3'd0; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      v.mode = SHL;
      v.sl   = 1'($urandom_range(0, 1));
      m_q    = {m_q[6:0], v.sl};
      m_done = (m_cnt == 3'd7);
      m_cnt  = m_done ? 3'd0 : m_cnt + 3'd1;
      v.ep = m_q; v.ec = m_cnt; v.ed = m_done; v.tag = "b2b";
      apply(v);
      if (frame_done) pulses++;
    end
    check("b2b.pulses", 8'(pulses), 8'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the team's fixed 8-bit serial-in/serial-out shift register.
- Adds configurable width, bidirectional shifting, parallel load/read, synchronous clear, frame counting and optional rotate.
- Used as the general serialiser/deserialiser primitive in datapaths that move words over single-bit links.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- RESET_VAL, 0, value loaded into the register on rst and on mode CLEAR; truncated to WIDTH bits.
- CW, $clog2(WIDTH), shift_cnt width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  operation enable; when 0 the block holds state.
- mode  in  3  operation select (encoding below).
- sin_lsb  in  1  serial bit entering bit 0 on shift-left.
- sin_msb  in  1  serial bit entering bit WIDTH-1 on shift-right.
- par_in  in  WIDTH  parallel load data.
- par_out  out  WIDTH  current register contents.
- sout_msb  out  1  bit WIDTH-1 of the register (shift-left serial output).
- sout_lsb  out  1  bit 0 of the register (shift-right serial output).
- shift_cnt  out  CW  shifts since last load/clear/reset, modulo WIDTH.
- frame_done  out  1  one-cycle pulse marking completion of WIDTH shifts.

Behaviour:
- All state updates on the rising edge of clk; rst is synchronous and active-high, already decided.
- rst has priority over en and mode. Reset values: register = RESET_VAL, shift_cnt = 0, frame_done = 0.
- Outputs par_out, sout_msb and sout_lsb are direct register views. A change is visible the cycle after the edge; there is no extra pipeline stage.
- en=0: register and shift_cnt hold; frame_done = 0.
- mode encoding (applies when en=1):
  - 000 HOLD: no change; frame_done = 0.
  - 001 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 010 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 011 LOAD: q <= par_in; shift_cnt <= 0; frame_done = 0.
  - 100 ROL / 101 ROR: see Optional Feature.
  - 110 CLEAR: q <= RESET_VAL; shift_cnt <= 0; frame_done = 0.
  - 111: reserved, behaves as HOLD.
- Shift operations (SHL, SHR, and ROL/ROR when enabled):
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and frame_done <= 1.
  - Otherwise: shift_cnt increments and frame_done <= 0.
- frame_done is registered, high for exactly one cycle per WIDTH shifts. Back-to-back frames produce a pulse every WIDTH shift cycles.
- Mixed-direction shifts within a frame each count; direction is not tracked.
- LOAD or CLEAR mid-frame aborts the frame: counter returns to 0 and no frame_done pulse is produced.
- rst mid-frame behaves the same way.
- With WIDTH a power of two, the counter wraps naturally. Otherwise it explicitly wraps at WIDTH-1; values at or above WIDTH are never reached.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined:
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - Both ignore the serial inputs and count as shifts for shift_cnt/frame_done.
- Undefined: modes 100 and 101 behave as HOLD (register and counter unchanged, frame_done = 0). No rotate logic is synthesised.

Test Plan (WIDTH=8, RESET_VAL=0):
- Reset: hold rst=1 for 2 cycles with en=1, mode=LOAD, par_in=8'hFF → par_out=8'h00, shift_cnt=0, frame_done=0. Confirms rst beats LOAD.
- Deserialise: mode=SHL, drive sin_lsb with 1,0,1,1,0,0,1,0 over 8 cycles → par_out=8'hB2. frame_done is high only in the cycle after the 8th edge; shift_cnt reads 0 then.
- Serialise: LOAD 8'hA5, then SHR with sin_msb=0 for 8 cycles → sout_lsb sequence 1,0,1,0,0,1,0,1; final par_out=8'h00; frame_done pulses once.
- Abort: SHL 5 cycles (shift_cnt=5), LOAD 8'h3C, SHL 7 cycles → no frame_done. The 8th post-load shift pulses frame_done.
- Enable/reserved: during SHL set en=0 for 3 cycles, then mode=111 for 2 cycles → par_out and shift_cnt frozen, frame_done=0 throughout.
- Rotate (USR_ROTATE_EN defined): LOAD 8'h81, ROL ×1 → 8'h03; ROR ×2 → 8'hC0; 8 ROLs total → original value returns and frame_done pulses. With the macro undefined, the same stimulus leaves 8'h81 unchanged.
